// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared widths, opcode map and sequencer state encoding for alu_op_sequencer
package alu_seq_pkg;

  localparam int DATA_W = 8;
  localparam int SEL_W  = 4;
  localparam int RES_W  = DATA_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } state_t;

  // Opcode map of bit8_alu; bit 8 of the result carries carry/borrow or shifted-out data
  localparam logic [SEL_W-1:0] OP_ADD  = 4'd0;
  localparam logic [SEL_W-1:0] OP_SUB  = 4'd1;
  localparam logic [SEL_W-1:0] OP_AND  = 4'd2;
  localparam logic [SEL_W-1:0] OP_OR   = 4'd3;
  localparam logic [SEL_W-1:0] OP_XOR  = 4'd4;
  localparam logic [SEL_W-1:0] OP_NOTA = 4'd5;
  localparam logic [SEL_W-1:0] OP_SHL  = 4'd6;
  localparam logic [SEL_W-1:0] OP_SHR  = 4'd7;
  localparam logic [SEL_W-1:0] OP_INC  = 4'd8;
  localparam logic [SEL_W-1:0] OP_DEC  = 4'd9;
  localparam logic [SEL_W-1:0] OP_NAND = 4'd10;
  localparam logic [SEL_W-1:0] OP_NOR  = 4'd11;
  localparam logic [SEL_W-1:0] OP_XNOR = 4'd12;
  localparam logic [SEL_W-1:0] OP_PASB = 4'd13;
  localparam logic [SEL_W-1:0] OP_EQ   = 4'd14;
  localparam logic [SEL_W-1:0] OP_LT   = 4'd15;

endpackage

// File: rtl/bit8_alu.sv
// rtl/bit8_alu.sv - combinational 8-bit ALU, 16 opcodes, 9-bit result
module bit8_alu
  import alu_seq_pkg::*;
(
  input  logic [DATA_W-1:0] i1,
  input  logic [DATA_W-1:0] i2,
  input  logic [SEL_W-1:0]  sel,
  output logic [RES_W-1:0]  o1
);

  always_comb begin
    o1 = '0;
    case (sel)
      OP_ADD:  o1 = {1'b0, i1} + {1'b0, i2};
      OP_SUB:  o1 = {1'b0, i1} - {1'b0, i2};
      OP_AND:  o1 = {1'b0, i1 & i2};
      OP_OR:   o1 = {1'b0, i1 | i2};
      OP_XOR:  o1 = {1'b0, i1 ^ i2};
      OP_NOTA: o1 = {1'b0, ~i1};
      OP_SHL:  o1 = {i1, 1'b0};
      OP_SHR:  o1 = {2'b00, i1[DATA_W-1:1]};
      OP_INC:  o1 = {1'b0, i1} + 9'd1;
      OP_DEC:  o1 = {1'b0, i1} - 9'd1;
      OP_NAND: o1 = {1'b0, ~(i1 & i2)};
      OP_NOR:  o1 = {1'b0, ~(i1 | i2)};
      OP_XNOR: o1 = {1'b0, ~(i1 ^ i2)};
      OP_PASB: o1 = {1'b0, i2};
      OP_EQ:   o1 = {8'd0, i1 == i2};
      OP_LT:   o1 = {8'd0, i1 < i2};
      default: o1 = '0;
    endcase
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - sweeps bit8_alu over a sel range, streams results on valid/ready
// Optional: define ALU_SIGNATURE_EN for a rotate-XOR signature of transferred results on sig_out.
module alu_op_sequencer
  import alu_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] a_in,
  input  logic [DATA_W-1:0] b_in,
  input  logic [SEL_W-1:0]  sel_first,
  input  logic [SEL_W-1:0]  sel_last,
  output logic              busy,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [RES_W-1:0]  res_data,
  output logic [SEL_W-1:0]  res_sel,
  output logic              done,
  output logic [RES_W-1:0]  sig_out
);

  state_t            state;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [SEL_W-1:0]  sel_cur;
  logic [SEL_W-1:0]  sel_end;
  logic [RES_W-1:0]  alu_o;
  logic              load;

  bit8_alu u_alu (
    .i1  (a_q),
    .i2  (b_q),
    .sel (sel_cur),
    .o1  (alu_o)
  );

  // The output register refills whenever it is empty or being drained this cycle
  assign load = (state == RUN) && (!res_valid || res_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      sel_cur   <= '0;
      sel_end   <= '0;
      busy      <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_sel   <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_q     <= a_in;
            b_q     <= b_in;
            sel_cur <= sel_first;
            sel_end <= sel_last;
            busy    <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          if (load) begin
            res_data  <= alu_o;
            res_sel   <= sel_cur;
            res_valid <= 1'b1;
            if (sel_cur == sel_end) begin
              state <= DRAIN;
            end else begin
              sel_cur <= sel_cur + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            done      <= 1'b1;
            state     <= FIN;
          end
        end
        FIN: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ALU_SIGNATURE_EN
  logic [RES_W-1:0] sig_q;
  logic             xfer;

  assign xfer = res_valid & res_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      sig_q <= '0;
    end else if (state == IDLE && start) begin
      sig_q <= '0;
    end else if (xfer) begin
      sig_q <= {sig_q[RES_W-2:0], sig_q[RES_W-1]} ^ res_data;
    end
  end

  assign sig_out = sig_q;
`else
  assign sig_out = '0;
`endif

endmodule
